id_stage_regfile_pipelined: RTL and testbench

- Parametrised instruction-decode stage: NUM_REGS x DATA_SIZE register bank, WB-to-ID bypass, load-use hazard detection, immediate-mode extension, and a registered ID/EX output bundle with valid/flush.
- Sits between the IF/ID register and EX; the debug unit freezes it via i_enable and inspects registers via a side read port.
- Pipeline behaviour: one-cycle registered latency; the stage inserts its own stall bubble.

---
 rtl/id_stage_regfile_pipelined.sv | 185 ++++++++++++++++++
 tb/tb_id_stage_regfile_pipelined.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_regfile_pipelined.sv
// ---------------------------------------------------------------------------
// id_stage_regfile_pipelined
//
// Instruction-decode stage. Holds the NUM_REGS x DATA_SIZE register bank,
// forwards the WB write into the same-cycle read, detects load-use hazards
// and inserts a one-cycle bubble, extends the immediate according to the
// opcode, and registers everything into the ID/EX bundle.
//
// Ports
//   i_clock, i_reset       rising-edge clock, asynchronous active-low reset
//   i_enable               0 freezes bank, ID/EX bundle and stall counter
//   i_valid, i_inst, i_pc  instruction from IF/ID (i_pc already holds PC+1)
//   i_flush                control-hazard flush, kills the next bundle
//   i_ex_mem_read, i_ex_rt load currently in EX and its destination
//   i_wb_write/addr/data   write-back port into the bank
//   i_dbg_addr, o_dbg_data debug side read (bank contents, no bypass)
//   o_stall                combinational: hold PC and IF/ID this cycle
//   o_stall_count          saturating count of stall cycles
//   o_valid ... o_pc       registered ID/EX bundle
//
// Valid semantics: there is no ready. o_valid qualifies the ID/EX bundle for
// exactly one cycle per edge; upstream is told to hold via o_stall, and a
// bubble (o_valid=0 with all fields zero) is emitted whenever the stage
// stalls or is flushed.
// ---------------------------------------------------------------------------
module id_stage_regfile_pipelined #(
  parameter int INST_SIZE = 32,
  parameter int PC_SIZE   = 32,
  parameter int DATA_SIZE = 32,
  parameter int REG_ADDR  = 5,
  parameter int NUM_REGS  = 32,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic [INST_SIZE-1:0] i_inst,
  input  logic [PC_SIZE-1:0]   i_pc,
  input  logic                 i_flush,
  input  logic                 i_ex_mem_read,
  input  logic [REG_ADDR-1:0]  i_ex_rt,
  input  logic                 i_wb_write,
  input  logic [REG_ADDR-1:0]  i_wb_addr,
  input  logic [DATA_SIZE-1:0] i_wb_data,
  input  logic [REG_ADDR-1:0]  i_dbg_addr,
  output logic [DATA_SIZE-1:0] o_dbg_data,
  output logic                 o_stall,
  output logic [CNT_SIZE-1:0]  o_stall_count,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_data_a,
  output logic [DATA_SIZE-1:0] o_data_b,
  output logic [DATA_SIZE-1:0] o_immediate,
  output logic [REG_ADDR-1:0]  o_rs,
  output logic [REG_ADDR-1:0]  o_rt,
  output logic [REG_ADDR-1:0]  o_rd,
  output logic [REG_ADDR-1:0]  o_shamt,
  output logic [PC_SIZE-1:0]   o_pc
);

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;

  // NUM_REGS <= 2**REG_ADDR, so it always fits in REG_ADDR+1 bits.
  localparam logic [REG_ADDR:0] NUM_REGS_W = (REG_ADDR+1)'(NUM_REGS);

  logic [DATA_SIZE-1:0] regs [NUM_REGS];

  // Instruction fields
  logic [5:0]           opcode;
  logic [REG_ADDR-1:0]  rs;
  logic [REG_ADDR-1:0]  rt;
  logic [REG_ADDR-1:0]  rd;
  logic [REG_ADDR-1:0]  shamt;
  logic [15:0]          imm16;

  assign opcode = i_inst[31:26];
  assign rs     = REG_ADDR'(i_inst[25:21]);
  assign rt     = REG_ADDR'(i_inst[20:16]);
  assign rd     = REG_ADDR'(i_inst[15:11]);
  assign shamt  = REG_ADDR'(i_inst[10:6]);
  assign imm16  = i_inst[15:0];

  // The funct field is decoded in EX, not here.
  logic unused_funct;
  assign unused_funct = ^i_inst[5:0];

  // Raw bank read: register 0 and out-of-range addresses read as zero.
  function automatic logic [DATA_SIZE-1:0] bank_rd(input logic [REG_ADDR-1:0] addr);
    if (addr == '0 || {1'b0, addr} >= NUM_REGS_W) return '0;
    return regs[addr];
  endfunction

  // Operand read with WB forwarding: the bank is written at the same edge
  // that captures the ID/EX bundle, so the in-flight WB value must be
  // picked up here to get write-before-read ordering.
  function automatic logic [DATA_SIZE-1:0] src_rd(input logic [REG_ADDR-1:0] addr);
    if (i_wb_write && i_wb_addr != '0 && i_wb_addr == addr) return i_wb_data;
    return bank_rd(addr);
  endfunction

  logic [DATA_SIZE-1:0] data_a;
  logic [DATA_SIZE-1:0] data_b;
  logic [DATA_SIZE-1:0] immediate;
  logic                 rt_use;
  logic                 wb_in_range;

  assign data_a     = src_rd(rs);
  assign data_b     = src_rd(rt);
  assign o_dbg_data = bank_rd(i_dbg_addr);

  always_comb begin
    immediate = {{(DATA_SIZE-16){imm16[15]}}, imm16};
    if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
      immediate = {{(DATA_SIZE-16){1'b0}}, imm16};
    else if (opcode == OP_LUI)
      immediate = {imm16, {(DATA_SIZE-16){1'b0}}};
  end

  // rt is a destination (lw, lui) or absent (j, jal) for these opcodes, so
  // a pending load into rt must not stall them.
  assign rt_use = !(opcode == OP_LW || opcode == OP_LUI ||
                    opcode == OP_J  || opcode == OP_JAL);

  assign o_stall = i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                   ((i_ex_rt == rs) || ((i_ex_rt == rt) && rt_use));

  assign wb_in_range = (i_wb_addr != '0) && ({1'b0, i_wb_addr} < NUM_REGS_W);

  // Register bank
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (i_enable && i_wb_write && wb_in_range) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  // ID/EX bundle and stall counter
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_valid       <= 1'b0;
      o_data_a      <= '0;
      o_data_b      <= '0;
      o_immediate   <= '0;
      o_rs          <= '0;
      o_rt          <= '0;
      o_rd          <= '0;
      o_shamt       <= '0;
      o_pc          <= '0;
      o_stall_count <= '0;
    end else if (i_enable) begin
      if (i_flush || o_stall) begin
        o_valid     <= 1'b0;
        o_data_a    <= '0;
        o_data_b    <= '0;
        o_immediate <= '0;
        o_rs        <= '0;
        o_rt        <= '0;
        o_rd        <= '0;
        o_shamt     <= '0;
        o_pc        <= '0;
        // A flushed stall is not a real stall cycle: it is not counted.
        if (!i_flush && o_stall_count != '1)
          o_stall_count <= o_stall_count + CNT_SIZE'(1);
      end else begin
        o_valid     <= i_valid;
        o_data_a    <= data_a;
        o_data_b    <= data_b;
        o_immediate <= immediate;
        o_rs        <= rs;
        o_rt        <= rt;
        o_rd        <= rd;
        o_shamt     <= shamt;
        o_pc        <= i_pc;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_regfile_pipelined.sv
module tb_id_stage_regfile_pipelined;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset;
  logic          i_enable;
  logic          i_valid;
  logic [31:0]   i_inst;
  logic [31:0]   i_pc;
  logic          i_flush;
  logic          i_ex_mem_read;
  logic [AW-1:0] i_ex_rt;
  logic          i_wb_write;
  logic [AW-1:0] i_wb_addr;
  logic [DW-1:0] i_wb_data;
  logic [AW-1:0] i_dbg_addr;
  logic [DW-1:0] o_dbg_data;
  logic          o_stall;
  logic [CW-1:0] o_stall_count;
  logic          o_valid;
  logic [DW-1:0] o_data_a;
  logic [DW-1:0] o_data_b;
  logic [DW-1:0] o_immediate;
  logic [AW-1:0] o_rs;
  logic [AW-1:0] o_rt;
  logic [AW-1:0] o_rd;
  logic [AW-1:0] o_shamt;
  logic [31:0]   o_pc;

  int n_checks = 0;
  int n_fail   = 0;

  id_stage_regfile_pipelined #(
    .INST_SIZE(32), .PC_SIZE(32), .DATA_SIZE(DW), .REG_ADDR(AW),
    .NUM_REGS(24), .CNT_SIZE(CW)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_inst(i_inst), .i_pc(i_pc), .i_flush(i_flush),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
    .i_wb_write(i_wb_write), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data),
    .o_stall(o_stall), .o_stall_count(o_stall_count), .o_valid(o_valid),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_immediate(o_immediate),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt), .o_pc(o_pc)
  );

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, 6'h20};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    i_valid = 0; i_inst = 0; i_pc = 0; i_flush = 0;
    i_ex_mem_read = 0; i_ex_rt = 0; i_wb_write = 0; i_wb_addr = 0; i_wb_data = 0;
    i_enable = 1;
  endtask

  task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_wb_write = 1; i_wb_addr = a; i_wb_data = d;
    tick();
    i_wb_write = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr_in(); i_dbg_addr = 5; i_reset = 0;
    repeat (2) tick();
    n_checks += 4;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h exp 0", o_valid); end
    if (o_data_a !== '0) begin n_fail++; $display("FAIL reset_data_a got %0h exp 0", o_data_a); end
    if (o_stall_count !== '0) begin n_fail++; $display("FAIL reset_count got %0h exp 0", o_stall_count); end
    if (o_dbg_data !== '0) begin n_fail++; $display("FAIL reset_bank got %0h exp 0", o_dbg_data); end
    i_reset = 1;
    tick();
  endtask

  task automatic test_write_read();
    clr_in();
    wb_write(5, 32'h1234);
    i_dbg_addr = 5; #1;
    n_checks++;
    if (o_dbg_data !== 32'h1234) begin n_fail++; $display("FAIL dbg_r5 got %0h exp 1234", o_dbg_data); end
    i_inst = mk_r(5, 0, 1, 7); i_valid = 1; i_pc = 32'h10;
    tick();
    n_checks += 6;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %0h exp 1", o_valid); end
    if (o_data_a !== 32'h1234) begin n_fail++; $display("FAIL add_data_a got %0h exp 1234", o_data_a); end
    if (o_data_b !== 32'h0) begin n_fail++; $display("FAIL add_data_b got %0h exp 0", o_data_b); end
    if (o_rs !== 5'd5 || o_rd !== 5'd1) begin n_fail++; $display("FAIL add_fields rs %0d rd %0d exp 5 1", o_rs, o_rd); end
    if (o_shamt !== 5'd7) begin n_fail++; $display("FAIL add_shamt got %0d exp 7", o_shamt); end
    if (o_pc !== 32'h10) begin n_fail++; $display("FAIL add_pc got %0h exp 10", o_pc); end
    // Bank boundary: 23 is the last entry, 25 is out of range.
    clr_in();
    wb_write(23, 32'h2323);
    wb_write(25, 32'h5555);
    i_dbg_addr = 23; #1;
    n_checks++;
    if (o_dbg_data !== 32'h2323) begin n_fail++; $display("FAIL dbg_r23 got %0h exp 2323", o_dbg_data); end
    i_dbg_addr = 25; #1;
    n_checks++;
    if (o_dbg_data !== 32'h0) begin n_fail++; $display("FAIL dbg_r25 got %0h exp 0", o_dbg_data); end
    i_inst = mk_r(25, 23, 2, 0); i_valid = 1;
    tick();
    n_checks += 2;
    if (o_data_a !== 32'h0) begin n_fail++; $display("FAIL oor_data_a got %0h exp 0", o_data_a); end
    if (o_data_b !== 32'h2323) begin n_fail++; $display("FAIL r23_data_b got %0h exp 2323", o_data_b); end
  endtask

  task automatic test_bypass();
    clr_in();
    i_inst = mk_r(7, 5, 2, 0); i_valid = 1;
    i_wb_write = 1; i_wb_addr = 7; i_wb_data = 32'hAAAA;
    tick();
    n_checks += 2;
    if (o_data_a !== 32'hAAAA) begin n_fail++; $display("FAIL bypass_a got %0h exp aaaa", o_data_a); end
    if (o_data_b !== 32'h1234) begin n_fail++; $display("FAIL bypass_b got %0h exp 1234", o_data_b); end
    i_inst = mk_r(0, 0, 3, 0);
    i_wb_addr = 0; i_wb_data = 32'hFFFF;
    tick();
    i_wb_write = 0; i_dbg_addr = 0; #1;
    n_checks += 3;
    if (o_data_a !== 32'h0 || o_data_b !== 32'h0) begin n_fail++; $display("FAIL r0_bypass a %0h b %0h exp 0 0", o_data_a, o_data_b); end
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL r0_valid got %0h exp 1", o_valid); end
    if (o_dbg_data !== 32'h0) begin n_fail++; $display("FAIL r0_bank got %0h exp 0", o_dbg_data); end
  endtask

  task automatic test_load_use();
    clr_in();
    i_inst = mk_r(3, 5, 4, 0); i_valid = 1; i_ex_mem_read = 1; i_ex_rt = 3; #1;
    n_checks++;
    if (o_stall !== 1'b1) begin n_fail++; $display("FAIL lu_rs_stall got %0h exp 1", o_stall); end
    tick();
    n_checks += 3;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got %0h exp 0", o_valid); end
    if (o_stall_count !== 2'd1) begin n_fail++; $display("FAIL lu_count got %0d exp 1", o_stall_count); end
    if (o_rs !== '0) begin n_fail++; $display("FAIL lu_bubble_rs got %0d exp 0", o_rs); end
    i_ex_mem_read = 0; #1;
    n_checks++;
    if (o_stall !== 1'b0) begin n_fail++; $display("FAIL lu_release got %0h exp 0", o_stall); end
    tick();
    n_checks += 2;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL lu_resume got %0h exp 1", o_valid); end
    if (o_data_b !== 32'h1234) begin n_fail++; $display("FAIL lu_resume_b got %0h exp 1234", o_data_b); end
    // Hazard through rt of an R-type
    i_inst = mk_r(5, 3, 4, 0); i_ex_mem_read = 1; #1;
    n_checks++;
    if (o_stall !== 1'b1) begin n_fail++; $display("FAIL lu_rt_stall got %0h exp 1", o_stall); end
    tick();
    n_checks++;
    if (o_stall_count !== 2'd2) begin n_fail++; $display("FAIL lu_rt_count got %0d exp 2", o_stall_count); end
    // Load into r0 never stalls
    i_ex_rt = 0; i_inst = mk_r(0, 0, 4, 0); #1;
    n_checks++;
    if (o_stall !== 1'b0) begin n_fail++; $display("FAIL lu_r0 got %0h exp 0", o_stall); end
    // lw's rt is a destination
    i_ex_rt = 3; i_inst = mk_i(6'h23, 5, 3, 16'h0004); #1;
    n_checks++;
    if (o_stall !== 1'b0) begin n_fail++; $display("FAIL lu_lw got %0h exp 0", o_stall); end
    tick();
    n_checks += 3;
    if (o_valid !== 1'b1 || o_rt !== 5'd3) begin n_fail++; $display("FAIL lw_fields valid %0h rt %0d exp 1 3", o_valid, o_rt); end
    if (o_immediate !== 32'h4) begin n_fail++; $display("FAIL lw_imm got %0h exp 4", o_immediate); end
    if (o_stall_count !== 2'd2) begin n_fail++; $display("FAIL lw_count got %0d exp 2", o_stall_count); end
    // No instruction, no stall
    i_valid = 0; i_inst = mk_r(3, 3, 4, 0); #1;
    n_checks++;
    if (o_stall !== 1'b0) begin n_fail++; $display("FAIL lu_invalid got %0h exp 0", o_stall); end
  endtask

  task automatic test_immediates();
    logic [5:0]  ops [4];
    logic [15:0] imms[4];
    logic [31:0] exps[4];
    ops[0] = 6'h08; imms[0] = 16'hFFF0; exps[0] = 32'hFFFFFFF0;
    ops[1] = 6'h0D; imms[1] = 16'hFFF0; exps[1] = 32'h0000FFF0;
    ops[2] = 6'h0F; imms[2] = 16'hFFF0; exps[2] = 32'hFFF00000;
    ops[3] = 6'h0C; imms[3] = 16'h8000; exps[3] = 32'h00008000;
    clr_in();
    for (int k = 0; k < 4; k++) begin
      i_inst = mk_i(ops[k], 5, 6, imms[k]); i_valid = 1;
      tick();
      n_checks++;
      if (o_immediate !== exps[k]) begin
        n_fail++; $display("FAIL imm_op%0h got %0h exp %0h", ops[k], o_immediate, exps[k]);
      end
    end
  endtask

  task automatic test_flush_enable();
    clr_in();
    i_inst = mk_r(5, 0, 6, 0); i_valid = 1;
    tick();
    i_inst = mk_r(3, 0, 6, 0); i_ex_mem_read = 1; i_ex_rt = 3; i_flush = 1; #1;
    n_checks++;
    if (o_stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall_comb got %0h exp 1", o_stall); end
    tick();
    n_checks += 2;
    if (o_valid !== 1'b0 || o_data_a !== '0) begin n_fail++; $display("FAIL flush_bubble valid %0h a %0h exp 0 0", o_valid, o_data_a); end
    if (o_stall_count !== 2'd2) begin n_fail++; $display("FAIL flush_count got %0d exp 2", o_stall_count); end
    i_flush = 0; i_ex_mem_read = 0; i_inst = mk_r(5, 7, 8, 0); i_pc = 32'h44;
    tick();
    n_checks++;
    if (o_valid !== 1'b1 || o_data_b !== 32'hAAAA) begin n_fail++; $display("FAIL pre_freeze valid %0h b %0h exp 1 aaaa", o_valid, o_data_b); end
    // Frozen: WB write, new instruction and a stall condition all ignored
    i_enable = 0; i_wb_write = 1; i_wb_addr = 9; i_wb_data = 32'hBEEF;
    i_inst = mk_r(9, 9, 10, 0); i_pc = 32'h48; i_ex_mem_read = 1; i_ex_rt = 9;
    tick();
    i_dbg_addr = 9; #1;
    n_checks += 4;
    if (o_valid !== 1'b1 || o_rs !== 5'd5) begin n_fail++; $display("FAIL freeze_fields valid %0h rs %0d exp 1 5", o_valid, o_rs); end
    if (o_pc !== 32'h44 || o_data_a !== 32'h1234) begin n_fail++; $display("FAIL freeze_data pc %0h a %0h exp 44 1234", o_pc, o_data_a); end
    if (o_stall_count !== 2'd2) begin n_fail++; $display("FAIL freeze_count got %0d exp 2", o_stall_count); end
    if (o_dbg_data !== 32'h0) begin n_fail++; $display("FAIL freeze_bank got %0h exp 0", o_dbg_data); end
    clr_in();
    tick();
  endtask

  task automatic test_saturation();
    logic [CW-1:0] exp_cnt;
    clr_in();
    i_reset = 0; #2; i_reset = 1; #1;
    n_checks++;
    if (o_stall_count !== '0) begin n_fail++; $display("FAIL sat_start got %0d exp 0", o_stall_count); end
    i_inst = mk_r(3, 0, 1, 0); i_valid = 1; i_ex_mem_read = 1; i_ex_rt = 3;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_cnt = (k < 3) ? CW'(k) : 2'd3;
      n_checks++;
      if (o_stall_count !== exp_cnt) begin
        n_fail++; $display("FAIL sat_step%0d got %0d exp %0d", k, o_stall_count, exp_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    clr_in();
    wb_write(5, 32'h77);
    i_reset = 0; #2; i_reset = 1;
    wb_write(5, 32'h77);
    i_inst = mk_r(5, 0, 1, 0); i_valid = 1; i_ex_mem_read = 1; i_ex_rt = 5;
    tick();
    i_ex_mem_read = 0; i_pc = 32'h20;
    tick();
    n_checks++;
    if (o_valid !== 1'b1 || o_data_a !== 32'h77 || o_stall_count !== 2'd1) begin
      n_fail++; $display("FAIL arst_pre valid %0h a %0h cnt %0d exp 1 77 1", o_valid, o_data_a, o_stall_count);
    end
    i_ex_mem_read = 1; i_dbg_addr = 5;
    #2; i_reset = 0; #1;
    n_checks += 5;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %0h exp 0", o_valid); end
    if (o_data_a !== '0 || o_pc !== '0) begin n_fail++; $display("FAIL arst_fields a %0h pc %0h exp 0 0", o_data_a, o_pc); end
    if (o_stall_count !== '0) begin n_fail++; $display("FAIL arst_count got %0d exp 0", o_stall_count); end
    if (o_dbg_data !== '0) begin n_fail++; $display("FAIL arst_bank got %0h exp 0", o_dbg_data); end
    if (o_stall !== 1'b1) begin n_fail++; $display("FAIL arst_stall_comb got %0h exp 1", o_stall); end
    #2; i_reset = 1;
    clr_in();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clr_in(); i_dbg_addr = 0; i_reset = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_load_use();
    test_immediates();
    test_flush_enable();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
